// File: rtl/ct_lsu_wb_pkg.sv
// Shared definitions for the N-channel store writeback stage:
// arbitration mode encodings, default field widths and the source-index width helper.
package ct_lsu_wb_pkg;

    localparam int ARB_FIXED     = 0;
    localparam int ARB_RR        = 1;

    localparam int DFLT_NUM_SRC  = 3;
    localparam int DFLT_IID_W    = 7;
    localparam int DFLT_EXPT_W   = 15;
    localparam int DFLT_MTVAL_W  = 64;

    // At least one bit, so a degenerate single-source build still has a legal index port.
    function automatic int src_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SRC_ID_W      = src_id_w(DFLT_NUM_SRC);

endpackage

// File: rtl/ct_lsu_wb_arb.sv
// Single-winner arbiter for the store writeback stage: fixed priority with aging,
// or round-robin, selected at elaboration time. Grant is purely combinational.
module ct_lsu_wb_arb
    import ct_lsu_wb_pkg::*;
#(
    parameter  int NUM_SRC  = DFLT_NUM_SRC,
    parameter  int ARB_MODE = ARB_FIXED,
    parameter  int AGE_MAX  = 7,
    localparam int SID_W    = src_id_w(NUM_SRC)
) (
    input  logic               ctrl_st_clk,
    input  logic               cpurst_b,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grnt,
    output logic [SID_W-1:0]   grnt_id
);

    localparam int AGE_W = 4;

    logic [NUM_SRC-1:0] cand;
    logic               any_req;
    logic               found;

    assign any_req = |req;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            logic [SID_W-1:0]   ptr_reg;
            logic [NUM_SRC-1:0] at_or_above;

            // Requests at or above the pointer get first pick; otherwise wrap to the bottom.
            for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_mask
                assign at_or_above[gi] = (gi >= int'(ptr_reg));
            end

            assign cand = (|(req & at_or_above)) ? (req & at_or_above) : req;

            always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    ptr_reg <= '0;
                end else if (any_req) begin
                    ptr_reg <= (int'(grnt_id) == NUM_SRC - 1) ? '0 : grnt_id + 1'b1;
                end
            end
        end else begin : g_fixed
            logic [AGE_W-1:0]   age_reg [NUM_SRC];
            logic [NUM_SRC-1:0] aged;

            for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_age
                assign aged[gi] = req[gi] && (age_reg[gi] == AGE_W'(AGE_MAX));

                always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
                    if (!cpurst_b) begin
                        age_reg[gi] <= '0;
                    end else if (req[gi] && !grnt[gi]) begin
                        if (age_reg[gi] != AGE_W'(AGE_MAX)) begin
                            age_reg[gi] <= age_reg[gi] + 1'b1;
                        end
                    end else begin
                        age_reg[gi] <= '0;
                    end
                end
            end

            // Starved channels pre-empt plain priority; ties among them still go lowest-first.
            assign cand = (|aged) ? aged : req;
        end
    endgenerate

    always_comb begin
        grnt    = '0;
        grnt_id = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && !found) begin
                grnt[i] = 1'b1;
                grnt_id = SID_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_lsu_st_wb_nch.sv
// N-channel store writeback stage: grants one complete request per cycle and
// presents the winner on the RTU pipe4 complete interface one cycle later.
module ct_lsu_st_wb_nch
    import ct_lsu_wb_pkg::*;
#(
    parameter  int NUM_SRC  = DFLT_NUM_SRC,
    parameter  int IID_W    = DFLT_IID_W,
    parameter  int EXPT_W   = DFLT_EXPT_W,
    parameter  int MTVAL_W  = DFLT_MTVAL_W,
    parameter  int ARB_MODE = ARB_FIXED,
    parameter  int AGE_MAX  = 7,
    localparam int SID_W    = src_id_w(NUM_SRC)
) (
    input  logic                     ctrl_st_clk,
    input  logic                     cpurst_b,
    input  logic                     rtu_yy_xx_flush,
    input  logic [NUM_SRC-1:0]       src_req,
    input  logic [NUM_SRC*IID_W-1:0] src_iid,
    input  logic [NUM_SRC-1:0]       src_inst_flush,
    input  logic [NUM_SRC-1:0]       src_spec_fail,
    input  logic [NUM_SRC-1:0]       src_bkpta,
    input  logic [NUM_SRC-1:0]       src_bkptb,
    input  logic                     src0_expt_vld,
    input  logic [EXPT_W-1:0]        src0_expt_vec,
    input  logic [MTVAL_W-1:0]       src0_mtval,
    output logic [NUM_SRC-1:0]       src_grnt,
    output logic                     wb_cmplt,
    output logic [IID_W-1:0]         wb_iid,
    output logic [SID_W-1:0]         wb_src_id,
    output logic                     wb_expt_vld,
    output logic [EXPT_W-1:0]        wb_expt_vec,
    output logic [MTVAL_W-1:0]       wb_mtval,
    output logic                     wb_spec_fail,
    output logic                     wb_flush,
    output logic                     wb_abnormal,
    output logic                     wb_bkpta,
    output logic                     wb_bkptb
);

    logic [NUM_SRC-1:0] grnt;
    logic [SID_W-1:0]   grnt_id;
    logic               any_grnt;

    logic [IID_W-1:0]   win_iid;
    logic               win_inst_flush;
    logic               win_spec_fail;
    logic               win_bkpta;
    logic               win_bkptb;
    logic               win_expt_vld;

    logic               cmplt_reg;
    logic [IID_W-1:0]   iid_reg;
    logic [SID_W-1:0]   src_id_reg;
    logic               expt_vld_reg;
    logic [EXPT_W-1:0]  expt_vec_reg;
    logic [MTVAL_W-1:0] mtval_reg;
    logic               spec_fail_reg;
    logic               flush_reg;
    logic               bkpta_reg;
    logic               bkptb_reg;

    ct_lsu_wb_arb #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE),
        .AGE_MAX  (AGE_MAX)
    ) x_ct_lsu_wb_arb (
        .ctrl_st_clk (ctrl_st_clk),
        .cpurst_b    (cpurst_b),
        .req         (src_req),
        .grnt        (grnt),
        .grnt_id     (grnt_id)
    );

    assign src_grnt = grnt;
    assign any_grnt = |grnt;

    // Grant is one-hot, so a select-and-OR mux needs no priority.
    always_comb begin
        win_iid        = '0;
        win_inst_flush = 1'b0;
        win_spec_fail  = 1'b0;
        win_bkpta      = 1'b0;
        win_bkptb      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grnt[i]) begin
                win_iid        = win_iid | src_iid[i*IID_W +: IID_W];
                win_inst_flush = win_inst_flush | src_inst_flush[i];
                win_spec_fail  = win_spec_fail  | src_spec_fail[i];
                win_bkpta      = win_bkpta      | src_bkpta[i];
                win_bkptb      = win_bkptb      | src_bkptb[i];
            end
        end
    end

    assign win_expt_vld = grnt[0] & src0_expt_vld;

    // A global flush still consumes the grant; only the complete strobe is suppressed.
    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cmplt_reg <= 1'b0;
        end else begin
            cmplt_reg <= any_grnt & ~rtu_yy_xx_flush;
        end
    end

    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            iid_reg       <= '0;
            src_id_reg    <= '0;
            expt_vld_reg  <= 1'b0;
            spec_fail_reg <= 1'b0;
            flush_reg     <= 1'b0;
            bkpta_reg     <= 1'b0;
            bkptb_reg     <= 1'b0;
        end else if (any_grnt) begin
            iid_reg       <= win_iid;
            src_id_reg    <= grnt_id;
            expt_vld_reg  <= win_expt_vld;
            spec_fail_reg <= win_spec_fail;
            flush_reg     <= (win_inst_flush | win_spec_fail) & ~win_expt_vld;
            bkpta_reg     <= win_bkpta;
            bkptb_reg     <= win_bkptb;
        end
    end

    // Exception payload is sticky: it only changes when a channel-0 exception completes.
    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            expt_vec_reg <= '0;
            mtval_reg    <= '0;
        end else if (win_expt_vld) begin
            expt_vec_reg <= src0_expt_vec;
            mtval_reg    <= src0_mtval;
        end
    end

    assign wb_cmplt     = cmplt_reg;
    assign wb_iid       = iid_reg;
    assign wb_src_id    = src_id_reg;
    assign wb_expt_vld  = expt_vld_reg;
    assign wb_expt_vec  = expt_vec_reg;
    assign wb_mtval     = mtval_reg;
    assign wb_spec_fail = spec_fail_reg;
    assign wb_flush     = flush_reg;
    assign wb_abnormal  = expt_vld_reg | flush_reg;
    assign wb_bkpta     = bkpta_reg;
    assign wb_bkptb     = bkptb_reg;

endmodule

// File: tb/tb_ct_lsu_st_wb_nch.sv
// Bench for the N-channel store writeback stage: a fixed-priority and a round-robin
// instance share stimulus and are checked every cycle against a behavioural model.
module tb_ct_lsu_st_wb_nch;

    localparam int N   = 3;
    localparam int IW  = 7;
    localparam int EW  = 15;
    localparam int MW  = 64;
    localparam int AM  = 7;
    localparam int SW  = 2;
    localparam int IDW = N * IW;

    logic           clk   = 1'b0;
    logic           rst_b = 1'b1;
    logic           flush = 1'b0;
    logic [N-1:0]   req    = '0;
    logic [IDW-1:0] iid    = '0;
    logic [N-1:0]   iflush = '0;
    logic [N-1:0]   sfail  = '0;
    logic [N-1:0]   bka    = '0;
    logic [N-1:0]   bkb    = '0;
    logic           e0v    = 1'b0;
    logic [EW-1:0]  e0vec  = '0;
    logic [MW-1:0]  e0mt   = '0;

    logic [1:0][N-1:0]  grnt;
    logic [1:0]         cmplt;
    logic [1:0][IW-1:0] w_iid;
    logic [1:0][SW-1:0] w_src;
    logic [1:0]         w_ev;
    logic [1:0][EW-1:0] w_vec;
    logic [1:0][MW-1:0] w_mt;
    logic [1:0]         w_sf;
    logic [1:0]         w_fl;
    logic [1:0]         w_ab;
    logic [1:0]         w_ba;
    logic [1:0]         w_bb;

    always #5 clk = ~clk;

    // Instance 0 runs fixed priority with aging, instance 1 round-robin.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ct_lsu_st_wb_nch #(
            .NUM_SRC  (N),
            .IID_W    (IW),
            .EXPT_W   (EW),
            .MTVAL_W  (MW),
            .ARB_MODE (gi),
            .AGE_MAX  (AM)
        ) dut (
            .ctrl_st_clk     (clk),
            .cpurst_b        (rst_b),
            .rtu_yy_xx_flush (flush),
            .src_req         (req),
            .src_iid         (iid),
            .src_inst_flush  (iflush),
            .src_spec_fail   (sfail),
            .src_bkpta       (bka),
            .src_bkptb       (bkb),
            .src0_expt_vld   (e0v),
            .src0_expt_vec   (e0vec),
            .src0_mtval      (e0mt),
            .src_grnt        (grnt[gi]),
            .wb_cmplt        (cmplt[gi]),
            .wb_iid          (w_iid[gi]),
            .wb_src_id       (w_src[gi]),
            .wb_expt_vld     (w_ev[gi]),
            .wb_expt_vec     (w_vec[gi]),
            .wb_mtval        (w_mt[gi]),
            .wb_spec_fail    (w_sf[gi]),
            .wb_flush        (w_fl[gi]),
            .wb_abnormal     (w_ab[gi]),
            .wb_bkpta        (w_ba[gi]),
            .wb_bkptb        (w_bb[gi])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state: per-channel wait counts, RR pointer, expected outputs.
    int          age [N];
    int          ptr;
    logic        m_cmplt [2];
    logic [IW-1:0] m_iid [2];
    int          m_src [2];
    logic        m_ev [2];
    logic [EW-1:0] m_vec [2];
    logic [MW-1:0] m_mt [2];
    logic        m_sf [2];
    logic        m_fl [2];
    logic        m_ba [2];
    logic        m_bb [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic string mname(input int m);
        return (m == 0) ? "fx" : "rr";
    endfunction

    // Winner index for the current inputs, or -1 when nobody requests.
    function automatic int model_win(input int m);
        if (req == '0) return -1;
        if (m == 0) begin
            for (int i = 0; i < N; i++) if (req[i] && age[i] == AM) return i;
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0;
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int m = 0; m < 2; m++) begin
            m_cmplt[m] = 0; m_iid[m] = '0; m_src[m] = 0; m_ev[m] = 0;
            m_vec[m] = '0; m_mt[m] = '0; m_sf[m] = 0; m_fl[m] = 0;
            m_ba[m] = 0; m_bb[m] = 0;
        end
    endtask

    task automatic model_update(input int m, input int w);
        if (w >= 0) begin
            m_cmplt[m] = !flush;
            m_iid[m]   = iid[w*IW +: IW];
            m_src[m]   = w;
            m_ev[m]    = (w == 0) && e0v;
            m_sf[m]    = sfail[w];
            m_fl[m]    = (iflush[w] || sfail[w]) && !m_ev[m];
            m_ba[m]    = bka[w];
            m_bb[m]    = bkb[w];
            if (m_ev[m]) begin
                m_vec[m] = e0vec;
                m_mt[m]  = e0mt;
            end
            if (m == 1) ptr = (w + 1) % N;
        end else begin
            m_cmplt[m] = 0;
        end
        if (m == 0) begin
            for (int i = 0; i < N; i++)
                age[i] = (req[i] && i != w) ? ((age[i] < AM) ? age[i] + 1 : AM) : 0;
        end
    endtask

    // One clock: compare everything at the falling edge, advance the model at the rising edge.
    task automatic step();
        int w [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            w[m] = model_win(m);
            chk({mname(m), " grnt"},  64'(grnt[m]), (w[m] < 0) ? 64'd0 : (64'd1 << w[m]));
            chk({mname(m), " cmplt"}, 64'(cmplt[m]), 64'(m_cmplt[m]));
            chk({mname(m), " iid"},   64'(w_iid[m]), 64'(m_iid[m]));
            chk({mname(m), " src"},   64'(w_src[m]), 64'(m_src[m]));
            chk({mname(m), " ev"},    64'(w_ev[m]),  64'(m_ev[m]));
            chk({mname(m), " vec"},   64'(w_vec[m]), 64'(m_vec[m]));
            chk({mname(m), " mtval"}, w_mt[m],       m_mt[m]);
            chk({mname(m), " sf"},    64'(w_sf[m]),  64'(m_sf[m]));
            chk({mname(m), " flush"}, 64'(w_fl[m]),  64'(m_fl[m]));
            chk({mname(m), " abn"},   64'(w_ab[m]),  64'(m_ev[m] | m_fl[m]));
            chk({mname(m), " bkpta"}, 64'(w_ba[m]),  64'(m_ba[m]));
            chk({mname(m), " bkptb"}, 64'(w_bb[m]),  64'(m_bb[m]));
        end
        @(posedge clk);
        model_update(0, w[0]);
        model_update(1, w[1]);
        #1;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst_b = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk({mname(m), " rst cmplt"}, 64'(cmplt[m]), 64'd0);
            chk({mname(m), " rst iid"},   64'(w_iid[m]), 64'd0);
            chk({mname(m), " rst src"},   64'(w_src[m]), 64'd0);
            chk({mname(m), " rst ev"},    64'(w_ev[m]),  64'd0);
            chk({mname(m), " rst vec"},   64'(w_vec[m]), 64'd0);
            chk({mname(m), " rst mtval"}, w_mt[m],       64'd0);
            chk({mname(m), " rst flags"}, 64'({w_sf[m], w_fl[m], w_ab[m], w_ba[m], w_bb[m]}), 64'd0);
        end
        req = '0; flush = 0; iid = '0; iflush = '0; sfail = '0; bka = '0; bkb = '0;
        e0v = 0; e0vec = '0; e0mt = '0;
        #1;
        for (int m = 0; m < 2; m++) chk({mname(m), " rst grnt"}, 64'(grnt[m]), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Lowest index wins in fixed mode; fields appear one cycle later.
        req = 3'b011; iid = {7'd0, 7'd9, 7'd5};
        #1 chk("fx first grnt", 64'(grnt[0]), 64'h1);
        step();
        chk("fx first cmplt", 64'(cmplt[0]), 64'd1);
        chk("fx first iid",   64'(w_iid[0]), 64'd5);
        chk("fx first src",   64'(w_src[0]), 64'd0);

        // Aging: channel 1 is starved for 7 cycles, then served, then channel 0 again.
        do_reset();
        req = 3'b011;
        for (int c = 1; c <= 9; c++) begin
            #1 chk($sformatf("fx aging c%0d", c), 64'(grnt[0]), (c == 8) ? 64'h2 : 64'h1);
            step();
        end

        // Round-robin rotation from reset with everyone requesting.
        do_reset();
        req = 3'b111;
        for (int c = 0; c < 4; c++) begin
            logic [3:0] rr_exp;
            rr_exp = 4'b0001 << (c % 3);
            #1 chk($sformatf("rr rotate c%0d", c), 64'(grnt[1]), 64'(rr_exp));
            step();
        end

        // Channel-0 exception masks the instruction flush.
        req = 3'b001; e0v = 1; e0vec = 15'h0007; e0mt = 64'hDEAD_BEEF; iflush = 3'b001;
        step();
        chk("expt vld",   64'(w_ev[0]),  64'd1);
        chk("expt flush", 64'(w_fl[0]),  64'd0);
        chk("expt abn",   64'(w_ab[0]),  64'd1);
        chk("expt vec",   64'(w_vec[0]), 64'h7);
        chk("expt mtval", w_mt[0],       64'hDEAD_BEEF);
        req = '0; e0v = 0; iflush = '0;
        step();
        chk("expt hold mtval", w_mt[1], 64'hDEAD_BEEF);

        // Global flush in the grant cycle: grant issued, completion suppressed, pointer wraps.
        do_reset();
        req = 3'b100; flush = 1;
        #1 chk("flush fx grnt", 64'(grnt[0]), 64'h4);
        chk("flush rr grnt", 64'(grnt[1]), 64'h4);
        step();
        chk("flush fx cmplt", 64'(cmplt[0]), 64'd0);
        chk("flush rr cmplt", 64'(cmplt[1]), 64'd0);
        req = 3'b111; flush = 0;
        #1 chk("flush rr ptr wrap", 64'(grnt[1]), 64'h1);
        step();

        // Randomised traffic; requests stay sticky for a few cycles so aging saturates.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            iid    = IDW'($urandom);
            iflush = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            sfail  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bka    = N'($urandom);
            bkb    = N'($urandom);
            flush  = ($urandom_range(0, 7) == 0);
            e0v    = ($urandom_range(0, 2) == 0);
            e0vec  = EW'($urandom);
            e0mt   = {$urandom, $urandom};
            step();
        end

        // Reset while a completion is on the bus.
        req = 3'b001; flush = 0; e0v = 0; iflush = '0; sfail = '0;
        step();
        chk("midrst pre cmplt", 64'(cmplt[0]), 64'd1);
        do_reset();
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("midrst post grnt c%0d", c), 64'(grnt[0]), 64'd0);
            chk($sformatf("midrst post cmplt c%0d", c), 64'(cmplt[0]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_lsu_st_wb_nch.md
Name: ct_lsu_st_wb_nch

Overview:
- Parametrised N-channel store writeback stage.
- Arbitrates up to NUM_SRC complete requests per cycle (store DA pipe, WMB, future vector/AMO completers) and grants exactly one. Grant is combinational.
- Registers the winner for one cycle and drives the RTU pipe4 complete interface.
- Adds selectable fixed/round-robin arbitration and anti-starvation aging; the single-pair DA/WMB stage has neither.

Parameters:
- NUM_SRC, 3, number of request channels (2..8); channel 0 is the only exception-capable source.
- IID_W, 7, instruction id width.
- EXPT_W, 15, exception vector width.
- MTVAL_W, 64, mtval width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins) with aging; 1 = round-robin.
- AGE_MAX, 7, fixed mode only: denied cycles before a channel is promoted (1..15).

Ports:
- ctrl_st_clk  in  1  clock
- cpurst_b  in  1  async active-low reset
- rtu_yy_xx_flush  in  1  global pipeline flush
- src_req  in  NUM_SRC  per-channel complete request
- src_iid  in  NUM_SRC*IID_W  per-channel iid; channel i occupies bits [i*IID_W +: IID_W]
- src_inst_flush  in  NUM_SRC  request flush after this instruction
- src_spec_fail  in  NUM_SRC  speculation failure
- src_bkpta  in  NUM_SRC  breakpoint A data hit
- src_bkptb  in  NUM_SRC  breakpoint B data hit
- src0_expt_vld  in  1  channel-0 exception
- src0_expt_vec  in  EXPT_W  channel-0 exception vector
- src0_mtval  in  MTVAL_W  channel-0 mtval
- src_grnt  out  NUM_SRC  one-hot grant, same cycle as request
- wb_cmplt  out  1  registered complete valid
- wb_iid  out  IID_W  completing iid
- wb_src_id  out  clog2(NUM_SRC)  index of the winning channel
- wb_expt_vld  out  1  exception valid
- wb_expt_vec  out  EXPT_W  exception vector
- wb_mtval  out  MTVAL_W  mtval
- wb_spec_fail  out  1  speculation failure
- wb_flush  out  1  flush request
- wb_abnormal  out  1  wb_expt_vld | wb_flush
- wb_bkpta  out  1  breakpoint A
- wb_bkptb  out  1  breakpoint B

Behaviour:
- Reset: every output register is 0. The RR pointer is 0. All age counters are 0. src_grnt is combinational, so it is 0 whenever src_req is 0.
- Grant: src_grnt is one-hot or zero, and nonzero iff src_req is nonzero. Latency is one cycle: a request granted in cycle T appears on wb_* in cycle T+1. wb_* holds for exactly one cycle; no back-pressure.
- Fixed mode:
  - The winner is the lowest-index requester, unless some channel's age equals AGE_MAX.
  - If any channel has age == AGE_MAX, the lowest-index such channel wins.
  - A channel's age increments (saturating at AGE_MAX) each cycle it requests and is not granted. It clears when granted or when not requesting.
- RR mode:
  - The search starts at the pointer and wraps modulo NUM_SRC.
  - On any grant, pointer = (winner+1) mod NUM_SRC; wrap from NUM_SRC-1 goes to 0.
  - No grant leaves the pointer unchanged.
  - Age logic is absent.
- Captured fields: on any grant, register iid, spec_fail, bkpta and bkptb from the winner.
  - expt_vld = winner==0 & src0_expt_vld.
  - flush = (inst_flush | spec_fail) & !expt_vld.
- Exception fields: expt_vec and mtval load only when channel 0 is granted with src0_expt_vld; otherwise they hold their previous value. With no grant, the iid/bit registers also hold; only wb_cmplt drops.
- rtu_yy_xx_flush:
  - wb_cmplt is 0 in the next cycle.
  - Grants are still issued that cycle; the granted request is consumed and discarded.
  - The RR pointer and age counters update normally.
- Reset mid-operation: asynchronous return to reset values; any pending grant is lost.

Decomposition:
- Shared package ct_lsu_wb_pkg holds:
  - the ARB_MODE encodings (ARB_FIXED = 0, ARB_RR = 1);
  - localparam SRC_ID_W = clog2(NUM_SRC);
  - the default widths IID_W, EXPT_W and MTVAL_W.
- Sub-module ct_lsu_wb_arb owns the arbiter:
  - inputs: req vector;
  - outputs: one-hot grant and encoded winner index;
  - contains the RR pointer and age counters.
- The top level handles muxing, the pipeline registers and the RTU outputs.

Test Plan:
- Fixed mode, NUM_SRC=3: src_req=3'b011 with iid0=5, iid1=9 -> src_grnt=3'b001. Next cycle wb_cmplt=1, wb_iid=5, wb_src_id=0.
- Fixed aging, AGE_MAX=7: hold src_req=3'b011 continuously -> channel 1 receives its first grant on the 8th cycle (age 7), then channel 0 wins the following cycle.
- RR mode: src_req=3'b111 for 4 cycles from reset -> grants 001, 010, 100, 001; pointer wraps 2 -> 0.
- Channel-0 exception: src0_expt_vld=1, expt_vec=15'h0007, mtval=64'hDEAD_BEEF, inst_flush=1 -> next cycle wb_expt_vld=1, wb_flush=0, wb_abnormal=1, wb_expt_vec=15'h0007, wb_mtval=64'hDEAD_BEEF.
- Flush collision: rtu_yy_xx_flush=1 in the same cycle as src_req=3'b100 -> src_grnt=3'b100 and next-cycle wb_cmplt=0. In RR mode the pointer becomes 0.
- Reset mid-operation: assert cpurst_b low while wb_cmplt=1 -> all outputs are 0 immediately; after release with src_req=0, src_grnt=0 and wb_cmplt stays 0.
